mc_control_unit: RTL and testbench

Multicycle ARM control unit: a state machine that sequences one instruction over 3–5 cycles across a shared-memory datapath, replacing the single-cycle controller. It contains the main FSM, a parametrised ALU decoder, and conditional logic with a registered flags file. It sits between the instruction register and the multicycle datapath, driving every enable and mux select.

---
 rtl/mc_control_unit.sv | 178 +++++++++++++++++
 tb/tb_mc_control_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle ARM control FSM, ALU decoder and conditional flags; define MC_CTRL_BL_EN to execute BL with R14 link
module mc_control_unit #(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:12]         Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 LinkSel
);
  typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH} state_t;
  state_t state_q, state_d;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       rd15;
  logic [2:0] alu_op;
  logic       no_write, arith, valid;
  logic [1:0] flag_w;
  logic [1:0] flags_nz, flags_cv;
  logic       n, z, c, v, cond_ex, cond_ex_q;
  logic       pcw, irw, rw, mw, use_dec, exec;
  logic       unused;
  assign cond   = Instr[31:28];
  assign op     = Instr[27:26];
  assign funct  = Instr[25:20];
  assign rd15   = &Instr[15:12];
  assign unused = ^Instr[19:16];
  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01 && !funct[0], op == 2'b10};
  always_comb begin
    alu_op   = 3'd0;
    no_write = 1'b0;
    arith    = 1'b0;
    valid    = 1'b1;
    case (funct[4:1])
      4'b0100: arith = 1'b1;
      4'b0010: begin alu_op = 3'd1; arith = 1'b1; end
      4'b0000: alu_op = 3'd2;
      4'b1100: alu_op = 3'd3;
      4'b0001: alu_op = 3'd4;
      4'b1101: alu_op = 3'd5;
      4'b1010: begin alu_op = 3'd1; arith = 1'b1; no_write = 1'b1; end
      4'b1000: begin alu_op = 3'd2; no_write = 1'b1; end
      default: begin no_write = 1'b1; valid = 1'b0; end
    endcase
  end
  assign flag_w = valid ? {funct[0], funct[0] & arith} : 2'b00;
  assign {n, z} = flags_nz;
  assign {c, v} = flags_cv;
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c && !z;
      4'b1001: cond_ex = !c || z;
      4'b1010: cond_ex = n == v;
      4'b1011: cond_ex = n != v;
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = z || (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  assign exec = state_q == EXECR || state_q == EXECI;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else state_q <= state_d;
  end
  // Flags see only earlier instructions: CondExQ is captured at the end of DECODE, flags at the end of EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_nz  <= 2'b00;
      flags_cv  <= 2'b00;
      cond_ex_q <= 1'b0;
    end else begin
      if (exec && flag_w[1] && cond_ex_q) flags_nz <= ALUFlags[3:2];
      if (exec && flag_w[0] && cond_ex_q) flags_cv <= ALUFlags[1:0];
      if (state_q == DECODE) cond_ex_q <= cond_ex;
    end
  end
  always_comb begin
    state_d   = FETCH;
    pcw       = 1'b0;
    irw       = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    use_dec   = 1'b0;
    LinkSel   = 1'b0;
    case (state_q)
      FETCH: begin
        state_d   = DECODE;
        irw       = 1'b1;
        pcw       = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = op == 2'b01 ? MEMADR :
                    op == 2'b00 ? (funct[5] ? EXECI : EXECR) :
                    op == 2'b10 ? BRANCH : FETCH;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw        = cond_ex_q;
        pcw       = cond_ex_q && rd15;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mw     = cond_ex_q;
      end
      EXECR: begin
        use_dec = 1'b1;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcB = 2'b01;
        use_dec = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        rw  = cond_ex_q && !no_write;
        pcw = cond_ex_q && !no_write && rd15;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw       = cond_ex_q;
`ifdef MC_CTRL_BL_EN
        if (funct[4]) begin
          LinkSel = 1'b1;
          rw      = cond_ex_q;
        end
`endif
      end
      default: state_d = FETCH;
    endcase
  end
  assign ALUControl = ALUCTRL_W'(use_dec ? alu_op : 3'd0);
  assign PCWrite    = reset & pcw;
  assign IRWrite    = reset & irw;
  assign RegWrite   = reset & rw;
  assign MemWrite   = reset & mw;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: table-driven per-cycle output vectors plus reset and decode corner sequences
module tb_mc_control_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:12] instr;
  logic [3:0]  alu_flags;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, LinkSel;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [13:0] obus;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       name;
    logic [19:0] instr;
    logic [3:0]  flags;
    logic [13:0] exp;
  } vec_t;
  vec_t vecs[$];
  localparam logic [13:0] F_O   = {6'b110001, 2'b10, 2'b10, 4'd0};
  localparam logic [13:0] D_O   = {6'b000001, 2'b10, 2'b10, 4'd0};
  localparam logic [13:0] MA_O  = {6'b000000, 2'b01, 2'b00, 4'd0};
  localparam logic [13:0] MR_O  = {6'b000010, 2'b00, 2'b00, 4'd0};
  localparam logic [13:0] MWB_O = {6'b000000, 2'b00, 2'b01, 4'd0};
  localparam logic [13:0] ER_O  = 14'd0;
  localparam logic [13:0] EI_O  = {6'b000000, 2'b01, 2'b00, 4'd0};
  localparam logic [13:0] AW_O  = 14'd0;
  localparam logic [13:0] BR_O  = {6'b000000, 2'b01, 2'b10, 4'd0};
  localparam logic [13:0] PCW = 14'h2000, RW = 14'h0800, MW = 14'h0400, LNK = 14'h0001;
  localparam logic [13:0] A_SUB = 14'd2, A_AND = 14'd4, A_ORR = 14'd6, A_EOR = 14'd8, A_MOV = 14'd10;
`ifdef MC_CTRL_BL_EN
  localparam logic [13:0] BL_O = BR_O | PCW | RW | LNK;
`else
  localparam logic [13:0] BL_O = BR_O | PCW;
`endif
  mc_control_unit #(.ALUCTRL_W(3)) dut (
    .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .LinkSel(LinkSel)
  );
  assign obus = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, LinkSel};
  always #5 clk = ~clk;
  function automatic logic [19:0] ins(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] rd);
    return {c, o, f, 4'd0, rd};
  endfunction
  task automatic add(input string n, input logic [19:0] i, input logic [3:0] f, input logic [13:0] e);
    vec_t r;
    r.name = n; r.instr = i; r.flags = f; r.exp = e;
    vecs.push_back(r);
  endtask
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic seq(input string n, input logic [19:0] i, input logic [3:0] f, input logic [13:0] e[]);
    foreach (e[k]) add($sformatf("%s_c%0d", n, k), i, k == 2 ? f : 4'd0, e[k]);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    reset = 1'b0;
    instr = '0;
    alu_flags = 4'd0;
    seq("adds",    ins(4'hE, 2'b00, 6'b001001, 4'd1),  4'b0100, '{F_O, D_O, ER_O, AW_O | RW});
    seq("cmp_z",   ins(4'hE, 2'b00, 6'b010101, 4'd0),  4'b0100, '{F_O, D_O, ER_O | A_SUB, AW_O});
    seq("beq_t",   ins(4'h0, 2'b10, 6'b100000, 4'd0),  4'b0000, '{F_O, D_O, BR_O | PCW});
    seq("bne_f",   ins(4'h1, 2'b10, 6'b100000, 4'd0),  4'b0000, '{F_O, D_O, BR_O});
    seq("ldr",     ins(4'hE, 2'b01, 6'b011001, 4'd0),  4'b0000, '{F_O, D_O, MA_O, MR_O, MWB_O | RW});
    seq("ldr_pc",  ins(4'hE, 2'b01, 6'b011001, 4'd15), 4'b0000, '{F_O, D_O, MA_O, MR_O, MWB_O | RW | PCW});
    seq("cmp_c",   ins(4'hE, 2'b00, 6'b010101, 4'd0),  4'b0010, '{F_O, D_O, ER_O | A_SUB, AW_O});
    seq("streq_f", ins(4'h0, 2'b01, 6'b011000, 4'd0),  4'b0000, '{F_O, D_O, MA_O, MR_O});
    seq("str",     ins(4'hE, 2'b01, 6'b011000, 4'd3),  4'b0000, '{F_O, D_O, MA_O, MR_O | MW});
    seq("tst",     ins(4'hE, 2'b00, 6'b010001, 4'd0),  4'b1000, '{F_O, D_O, ER_O | A_AND, AW_O});
    seq("bmi_t",   ins(4'h4, 2'b10, 6'b100000, 4'd0),  4'b0000, '{F_O, D_O, BR_O | PCW});
    seq("bcs_t",   ins(4'h2, 2'b10, 6'b100000, 4'd0),  4'b0000, '{F_O, D_O, BR_O | PCW});
    seq("f0111",   ins(4'hE, 2'b00, 6'b001111, 4'd1),  4'b0100, '{F_O, D_O, ER_O, AW_O});
    seq("beq_f",   ins(4'h0, 2'b10, 6'b100000, 4'd0),  4'b0000, '{F_O, D_O, BR_O});
    seq("blt_t",   ins(4'hB, 2'b10, 6'b100000, 4'd0),  4'b0000, '{F_O, D_O, BR_O | PCW});
    seq("addeq_f", ins(4'h0, 2'b00, 6'b001001, 4'd1),  4'b0100, '{F_O, D_O, ER_O, AW_O});
    seq("bpl_f",   ins(4'h5, 2'b10, 6'b100000, 4'd0),  4'b0000, '{F_O, D_O, BR_O});
    seq("orr_i",   ins(4'hE, 2'b00, 6'b111000, 4'd2),  4'b0000, '{F_O, D_O, EI_O | A_ORR, AW_O | RW});
    seq("eor_r",   ins(4'hE, 2'b00, 6'b000010, 4'd4),  4'b0000, '{F_O, D_O, ER_O | A_EOR, AW_O | RW});
    seq("mov_pc",  ins(4'hE, 2'b00, 6'b111010, 4'd15), 4'b0000, '{F_O, D_O, EI_O | A_MOV, AW_O | RW | PCW});
    seq("op11",    ins(4'hE, 2'b11, 6'b000000, 4'd0),  4'b0000, '{F_O, D_O});
    seq("bnv",     ins(4'hF, 2'b10, 6'b100000, 4'd0),  4'b0000, '{F_O, D_O, BR_O});
    seq("bl",      ins(4'hE, 2'b10, 6'b110000, 4'd0),  4'b0000, '{F_O, D_O, BL_O});
    seq("op11b",   ins(4'hE, 2'b11, 6'b000000, 4'd0),  4'b0000, '{F_O});
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", 16'({PCWrite, IRWrite, RegWrite, MemWrite}), 16'h0);
    chk("rst_flags", 16'({dut.flags_nz, dut.flags_cv}), 16'h0);
    chk("rst_fetch_outs", 16'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}), 16'({1'b0, 1'b1, 2'b10, 2'b10, 3'd0}));
    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[k]) begin
      instr = vecs[k].instr;
      alu_flags = vecs[k].flags;
      #1;
      chk(vecs[k].name, 16'(obus), 16'(vecs[k].exp));
      @(negedge clk);
    end
    instr = ins(4'hE, 2'b11, 6'b000000, 4'd0);
    @(negedge clk);
    instr = ins(4'hE, 2'b01, 6'b011000, 4'd3);
    #1;
    chk("str_immsrc_regsrc", 16'({ImmSrc, RegSrc}), 16'({2'b01, 2'b10}));
    repeat (3) @(negedge clk);
    #1;
    chk("str_memwrite_on", 16'(MemWrite), 16'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_we_drop", 16'({PCWrite, IRWrite, RegWrite, MemWrite}), 16'h0);
    chk("midrst_fetch", 16'({ALUSrcA, ALUSrcB, ResultSrc}), 16'({1'b1, 2'b10, 2'b10}));
    chk("midrst_flags", 16'({dut.flags_nz, dut.flags_cv}), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    instr = ins(4'h4, 2'b10, 6'b100000, 4'd0);
    #1;
    chk("post_rst_fetch", 16'(obus), 16'(F_O));
    chk("b_immsrc_regsrc", 16'({ImmSrc, RegSrc}), 16'({2'b10, 2'b01}));
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_bmi_f", 16'(obus), 16'(BR_O));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
